// File: rtl/sample_fifo_buf.sv
// Single-clock synchronous FIFO for tagged sample words with registered (non-FWFT) read data.
// Optional occupancy output data_count is enabled by defining SAMPLE_FIFO_DATA_COUNT_EN.
module sample_fifo_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  almost_full,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  valid,
  output logic                  underflow
`ifdef SAMPLE_FIFO_DATA_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   data_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF    = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_ok;
  logic                  rd_ok;

  // Handshake: a request is taken at the edge where its enable is high and the
  // pre-edge flag allows it; wr_ack/overflow and valid/underflow report that
  // decision as a one-cycle pulse after the edge, and valid marks new dout.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Storage is not reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      dout         <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      wr_ack       <= 1'b0;
      overflow     <= 1'b0;
      valid        <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (rd_ok) begin
        rptr <= rptr + PTR_ONE;
        dout <= mem[rptr];
      end
      count        <= count_next;
      full         <= (count_next == CNT_DEPTH);
      almost_full  <= (count_next >= CNT_AF);
      empty        <= (count_next == '0);
      almost_empty <= (count_next <= CNT_ONE);
      wr_ack       <= wr_ok;
      overflow     <= wr_en & full;
      valid        <= rd_ok;
      underflow    <= rd_en & empty;
    end
  end

`ifdef SAMPLE_FIFO_DATA_COUNT_EN
  assign data_count = count;
`endif

endmodule

// File: tb/tb_sample_fifo_buf.sv
// Directed bench for sample_fifo_buf at DEPTH=4; expected values are hand-computed.
// Covers fill/drain, overflow, underflow, simultaneous ops at the limits, wrap and async reset.
module tb_sample_fifo_buf;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          full;
  logic          almost_full;
  logic          wr_ack;
  logic          overflow;
  logic          empty;
  logic          almost_empty;
  logic          valid;
  logic          underflow;
`ifdef SAMPLE_FIFO_DATA_COUNT_EN
  logic [AW:0]   data_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sample_fifo_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .almost_full  (almost_full),
    .wr_ack       (wr_ack),
    .overflow     (overflow),
    .empty        (empty),
    .almost_empty (almost_empty),
    .valid        (valid),
    .underflow    (underflow)
`ifdef SAMPLE_FIFO_DATA_COUNT_EN
    ,
    .data_count   (data_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_count(input string tag, input int exp);
`ifdef SAMPLE_FIFO_DATA_COUNT_EN
    check(tag, 32'(data_count), 32'(exp));
`else
    if (exp < 0) $display("bad expected count for %s", tag);
`endif
  endtask

  // flags packed as {full, almost_full, almost_empty, empty}
  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, full, almost_full, almost_empty, empty}, {28'd0, exp});
  endtask

  // driver: present request for one edge, then sample 1 time unit after it
  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  logic [DW-1:0] fill_a [4];
  logic [DW-1:0] fill_b [4];

  initial begin
    fill_a = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
    fill_b = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04};
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0);
    check_flags("reset_flags", 4'b0011);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_strobes", {28'd0, wr_ack, overflow, underflow, 1'b0}, 32'h0);
    check_count("reset_count", 0);

    // fill: count 1..4
    cyc(1'b1, 1'b0, fill_a[0]);
    check("w1_ack", 32'(wr_ack), 32'h1);
    check_flags("w1_flags", 4'b0010);
    cyc(1'b1, 1'b0, fill_a[1]);
    check("w2_ack", 32'(wr_ack), 32'h1);
    check_flags("w2_flags", 4'b0000);
    check_count("w2_count", 2);
    cyc(1'b1, 1'b0, fill_a[2]);
    check("w3_ack", 32'(wr_ack), 32'h1);
    check_flags("w3_flags", 4'b0100);
    cyc(1'b1, 1'b0, fill_a[3]);
    check("w4_ack", 32'(wr_ack), 32'h1);
    check_flags("w4_flags", 4'b1100);
    check_count("w4_count", 4);

    // overflow
    cyc(1'b1, 1'b0, 16'h5005);
    check("ovf_pulse", 32'(overflow), 32'h1);
    check("ovf_ack", 32'(wr_ack), 32'h0);
    check_flags("ovf_flags", 4'b1100);
    cyc(1'b0, 1'b0, '0);
    check("ovf_clear", 32'(overflow), 32'h0);

    // drain in order
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, '0);
      check($sformatf("rd%0d_dout", i), 32'(dout), 32'(fill_a[i]));
      check($sformatf("rd%0d_valid", i), 32'(valid), 32'h1);
    end
    check_flags("drain_flags", 4'b0011);
    check_count("drain_count", 0);
    cyc(1'b0, 1'b0, '0);
    check("idle_valid", 32'(valid), 32'h0);

    // underflow
    cyc(1'b0, 1'b1, '0);
    check("udf_pulse", 32'(underflow), 32'h1);
    check("udf_valid", 32'(valid), 32'h0);
    check("udf_dout_hold", 32'(dout), 32'h4004);
    cyc(1'b0, 1'b0, '0);
    check("udf_clear", 32'(underflow), 32'h0);

    // full with simultaneous read+write
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, fill_b[i]);
    check_flags("fillb_flags", 4'b1100);
    cyc(1'b1, 1'b1, 16'hBEEF);
    check("fullrw_dout", 32'(dout), 32'h0A01);
    check("fullrw_valid", 32'(valid), 32'h1);
    check("fullrw_ovf", 32'(overflow), 32'h1);
    check("fullrw_ack", 32'(wr_ack), 32'h0);
    check_flags("fullrw_flags", 4'b0100);
    check_count("fullrw_count", 3);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0, 1'b1, '0);
      check($sformatf("rdb%0d_dout", i), 32'(dout), 32'(fill_b[i]));
    end
    check_flags("drainb_flags", 4'b0011);

    // empty with simultaneous read+write
    cyc(1'b1, 1'b1, 16'h0C0C);
    check("emptyrw_udf", 32'(underflow), 32'h1);
    check("emptyrw_ack", 32'(wr_ack), 32'h1);
    check("emptyrw_valid", 32'(valid), 32'h0);
    check("emptyrw_dout_hold", 32'(dout), 32'h0A04);
    check_flags("emptyrw_flags", 4'b0010);
    check_count("emptyrw_count", 1);
    cyc(1'b0, 1'b1, '0);
    check("emptyrw_rd_dout", 32'(dout), 32'h0C0C);
    check_flags("emptyrw_rd_flags", 4'b0011);

    // pointer wrap
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 16'(16'h0100 + i));
      cyc(1'b0, 1'b1, '0);
      check($sformatf("wrap%0d_dout", i), 32'(dout), 32'(16'h0100 + i));
    end

    // asynchronous reset mid-stream
    cyc(1'b1, 1'b0, 16'h7707);
    cyc(1'b1, 1'b0, 16'h7808);
    check_flags("prerst_flags", 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    check_flags("asyncrst_flags", 4'b0011);
    check("asyncrst_dout", 32'(dout), 32'h0);
    check_count("asyncrst_count", 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 16'h9909);
    cyc(1'b0, 1'b1, '0);
    check("postrst_dout", 32'(dout), 32'h9909);
    check_flags("postrst_flags", 4'b0011);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
